// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter with a one-byte holding register and sticky overrun flag
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] data,
  input  logic       clr_overrun,
  output logic       tx,
  output logic       busy,
  output logic       active,
  output logic       overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2:0]     idx;
  logic [7:0]     shift;
  logic [7:0]     hold;
  logic           bit_end;
  logic           accept;
  logic           drop;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign accept  = send && !busy;
  assign drop    = send && busy;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      hold    <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      active  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= drop ? 1'b1 : clr_overrun ? 1'b0 : overrun;
      cnt     <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
      if (accept && state != IDLE) begin
        hold <= data;
        busy <= 1'b1;
      end
      case (state)
        IDLE: begin
          // a byte held at the very end of STOP is launched from here
          if (busy) begin
            shift  <= hold;
            busy   <= 1'b0;
            state  <= START;
            tx     <= 1'b0;
            active <= 1'b1;
          end else if (accept) begin
            shift  <= data;
            state  <= START;
            tx     <= 1'b0;
            active <= 1'b1;
          end
        end
        START: if (bit_end) begin
          state <= DATA;
          tx    <= shift[0];
          idx   <= '0;
        end
        DATA: if (bit_end) begin
          shift <= shift >> 1;
          if (idx == 3'd7) begin
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            tx  <= shift[1];
            idx <= idx + 3'd1;
          end
        end
        STOP: if (bit_end) begin
          if (busy) begin
            shift <= hold;
            busy  <= 1'b0;
            state <= START;
            tx    <= 1'b0;
          end else begin
            state  <= IDLE;
            active <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed checks of framing, holding, overrun and reset with CLKS_PER_BIT=4
module tb_uart_transmitter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       send = 1'b0;
  logic [7:0] data = 8'h00;
  logic       clr_overrun = 1'b0;
  logic       tx, busy, active, overrun;
  int         nvec = 0;
  int         nerr = 0;
  logic       held = 1'b0;
  logic       ovr_exp = 1'b0;

  uart_transmitter #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .send(send), .data(data), .clr_overrun(clr_overrun),
    .tx(tx), .busy(busy), .active(active), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_tx"}, tx, 1'b1);
    chk({tag, "_active"}, active, 1'b0);
    chk({tag, "_busy"}, busy, held);
    chk({tag, "_overrun"}, overrun, ovr_exp);
  endtask

  task automatic accept(input logic [7:0] b);
    send = 1'b1;
    data = b;
    tick();
    send = 1'b0;
    data = 8'($urandom);
  endtask

  // Walks one 40-cycle frame starting in its first cycle; up to two sends and one clear are injected
  task automatic frame(input logic [7:0] b, input int inj1, input logic [7:0] d1,
                       input int inj2, input logic [7:0] d2, input int clr_at);
    int   k;
    logic e, hb, dropped;
    for (int i = 0; i < 40; i++) begin
      k = i / 4;
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      chk("frame_tx", tx, e);
      chk("frame_active", active, 1'b1);
      chk("frame_busy", busy, held);
      chk("frame_overrun", overrun, ovr_exp);
      hb = held;
      if (i == inj1) begin send = 1'b1; data = d1; end
      if (i == inj2) begin send = 1'b1; data = d2; end
      if (i == clr_at) clr_overrun = 1'b1;
      tick();
      dropped = (i == inj1 || i == inj2) && hb;
      if ((i == inj1 || i == inj2) && !hb) held = 1'b1;
      if (i == 39 && hb) held = 1'b0;
      ovr_exp = dropped ? 1'b1 : (i == clr_at) ? 1'b0 : ovr_exp;
      send = 1'b0;
      clr_overrun = 1'b0;
      data = 8'($urandom);
    end
  endtask

  initial begin
    tick();
    tick();
    idle_chk("reset");
    rst = 1'b1;
    accept(8'hA5);
    frame(8'hA5, -1, 8'h00, -1, 8'h00, -1);
    idle_chk("after_a5");
    tick();
    idle_chk("idle_gap");

    accept(8'h55);
    frame(8'h55, 4, 8'h0F, -1, 8'h00, -1);
    frame(8'h0F, -1, 8'h00, -1, 8'h00, -1);
    idle_chk("after_b2b");

    accept(8'h33);
    frame(8'h33, 2, 8'h81, 6, 8'hFF, -1);
    frame(8'h81, -1, 8'h00, -1, 8'h00, -1);
    idle_chk("after_ovr");
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    ovr_exp = 1'b0;
    chk("clr_overrun", overrun, 1'b0);

    accept(8'h12);
    frame(8'h12, 3, 8'h34, 39, 8'hEE, -1);
    frame(8'h34, 10, 8'h56, 12, 8'h9A, 12);
    frame(8'h56, -1, 8'h00, -1, 8'h00, 5);
    idle_chk("after_coinc");

    accept(8'hC3);
    accept(8'h11);
    held = 1'b1;
    chk("pre_rst_busy", busy, 1'b1);
    repeat (16) tick();
    chk("pre_rst_tx", tx, 1'b0);
    rst = 1'b0;
    #1;
    held = 1'b0;
    ovr_exp = 1'b0;
    idle_chk("async_rst");
    tick();
    tick();
    idle_chk("in_rst");
    rst = 1'b1;
    accept(8'h00);
    frame(8'h00, -1, 8'h00, -1, 8'h00, -1);
    idle_chk("after_rst_frame");
    tick();
    idle_chk("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104: clock cycles per serial bit, legal range 2..65535.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset; asserted when 0.
REQ-004 SHALL have port send, input, 1 bit: request to queue the byte on data this cycle.
REQ-005 SHALL have port data, input, 8 bits: byte to transmit, sampled only when a send is accepted.
REQ-006 SHALL have port clr_overrun, input, 1 bit: clears the sticky overrun flag.
REQ-007 SHALL have port tx, output, 1 bit: serial line, idle high, 8N1 framing.
REQ-008 SHALL have port busy, output, 1 bit: holding register full; a new send is not accepted.
REQ-009 SHALL have port active, output, 1 bit: a frame is currently being shifted out.
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag, set when a send was dropped.

Function
REQ-011 SHALL implement an FSM with states IDLE, START, DATA, STOP, plus a baud counter of width clog2(CLKS_PER_BIT) and a 3-bit bit index.
REQ-012 SHALL accept a send on any rising edge where send=1 and busy=0; data is captured on that edge.
REQ-013 SHALL, on acceptance in IDLE with the holding register empty, load the byte directly into the shift register and enter START on the same edge.
REQ-014 SHALL, on acceptance outside IDLE, store the byte in the holding register and set busy=1 from the next cycle.
REQ-015 SHALL drive tx=0 in START, tx=shift[0] in DATA, and tx=1 in STOP and IDLE; tx SHALL be registered (glitch-free).
REQ-016 SHALL hold each of START, each DATA bit, and STOP for exactly CLKS_PER_BIT cycles; a frame is 10*CLKS_PER_BIT cycles.
REQ-017 SHALL send DATA bits LSB first, shifting right after each bit period; it SHALL leave DATA after bit index 7 completes.
REQ-018 SHALL, at the end of STOP with the holding register full, move the holding byte to the shift register, clear busy, and enter START on the same edge, leaving no idle gap between frames.
REQ-019 SHALL, at the end of STOP with the holding register empty, return to IDLE.
REQ-020 SHALL, when send=1 and busy=1 on an edge, drop the byte, leave the holding register unchanged, and set overrun=1.
REQ-021 SHALL, when the end of STOP coincides with send=1 and busy=1, drop the incoming byte and set overrun, because busy is evaluated before the transfer.
REQ-022 SHALL clear overrun on clr_overrun=1; if a set condition occurs in the same cycle, set wins.
REQ-023 SHALL drive active=1 in START, DATA and STOP, and active=0 in IDLE.
REQ-024 SHALL ignore data whenever no send is accepted.

Reset
REQ-025 SHALL, while rst=0, force the FSM to IDLE, and force tx=1, busy=0, active=0 and overrun=0, with the baud counter, bit index, shift register and holding register at 0.
REQ-026 SHALL abort any in-progress frame and discard a held byte on reset; tx SHALL return high immediately (asynchronously).
REQ-027 SHALL begin accepting sends on the first rising edge after rst deasserts.

Verification (CLKS_PER_BIT=4)
REQ-028 Single byte: send 0xA5 from idle -> tx low for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; active high for 40 cycles; busy stays 0.
REQ-029 Back-to-back: send 0x55, then 0x0F 5 cycles later -> busy=1 until the first STOP ends; the second start bit begins on the cycle immediately after the first STOP; total 80 cycles with active=1 throughout.
REQ-030 Overrun: with busy=1, send 0xFF -> byte absent from the line, overrun=1 and sticky; pulse clr_overrun -> overrun=0.
REQ-031 Reset mid-frame: assert rst during DATA bit 3 with a byte held -> tx=1, busy=0, active=0 at once; after release, send 0x00 -> a clean fresh frame.
REQ-032 Coincidence: send with busy=1 on the final STOP cycle -> held byte transmitted, new byte dropped, overrun=1; clr_overrun together with a new drop -> overrun stays 1.
